// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 codes, FSM state type, request decode helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a. Optional feature macro: MISALIGN_TRAP_EN (defined: misaligned accesses fault; undefined: aligned down).
package lsu_pkg;

    localparam int XLEN      = 64;
    localparam int MEM_IDX_W = 10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    // funct3[1:0] encodes the access size for every legal load and store code.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

    // Clears the offset bits below the access size so the access lands aligned
    // within its doubleword. A no-op for aligned accesses.
    function automatic logic [2:0] align_off(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b01:   return {off[2:1], 1'b0};
            2'b10:   return {off[2], 2'b00};
            2'b11:   return 3'b000;
            default: return off;
        endcase
    endfunction

    function automatic logic is_fault(input logic store, input logic [2:0] f3, input logic [2:0] off);
        logic illegal;
        illegal = store ? f3[2] : (f3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
        return illegal | is_misaligned(f3, off);
`else
        return illegal;
`endif
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extract+extend a load lane from a doubleword, and merge store bytes into one.
// Latency: combinational.
// Backpressure: none; ports i_rdata/i_wdata/i_off/i_f3 in, o_load/o_merge out.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,   // doubleword read from memory
    input  logic [XLEN-1:0] i_wdata,   // store data, LSB-aligned
    input  logic [2:0]      i_off,     // byte offset within the doubleword
    input  logic [2:0]      i_f3,      // funct3 width/sign code
    output logic [XLEN-1:0] o_load,    // extracted, extended load value
    output logic [XLEN-1:0] o_merge    // i_rdata with addressed bytes replaced
);

    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_wsh;
    logic [XLEN-1:0] w_mask;
    logic [7:0]      w_size_mask;
    logic [7:0]      w_bmask;
    logic            w_sgn;

    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        w_wsh   = i_wdata << {i_off, 3'b000};
        w_sgn   = ~i_f3[2];   // funct3[2]=1 marks the unsigned loads

        case (i_f3[1:0])
            2'b00:   o_load = {{(XLEN-8){w_shift[7] & w_sgn}},   w_shift[7:0]};
            2'b01:   o_load = {{(XLEN-16){w_shift[15] & w_sgn}}, w_shift[15:0]};
            2'b10:   o_load = {{(XLEN-32){w_shift[31] & w_sgn}}, w_shift[31:0]};
            default: o_load = w_shift;
        endcase

        case (i_f3[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
        w_bmask = w_size_mask << i_off;

        w_mask = '0;
        for (int b = 0; b < 8; b++) begin
            w_mask[b*8 +: 8] = {8{w_bmask[b]}};
        end
        o_merge = (i_rdata & ~w_mask) | (w_wsh & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: turns LB..LD/SB..SD into doubleword memory ops (read-modify-write for sub-doubleword stores).
// Latency accept->resp_valid: load 2, SD 2, SB/SH/SW 3, fault 1. Build option: MISALIGN_TRAP_EN.
// Backpressure: i_req_valid/o_req_ready (ready only in IDLE); o_resp_valid held with stable data until i_resp_ready.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_store,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_fault,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata
);

    lsu_state_t             r_state;
    logic                   r_store;
    logic [2:0]             r_f3;
    logic [MEM_IDX_W+2:0]   r_addr;     // doubleword index + (aligned) byte offset
    logic [XLEN-1:0]        r_wdata;
    logic [XLEN-1:0]        r_rdata;
    logic                   r_fault;
    logic [XLEN-1:0]        r_mem_wdata;

    logic [XLEN-1:0]        w_load;
    logic [XLEN-1:0]        w_merge;
    logic [2:0]             w_req_off;
    logic                   w_req_fault;
    logic                   w_unused_addr;

    // Address bits above the memory index are dropped, so out-of-range accesses wrap.
    assign w_unused_addr = ^i_req_addr[XLEN-1:MEM_IDX_W+3];

    assign w_req_off   = align_off(i_req_funct3, i_req_addr[2:0]);
    assign w_req_fault = is_fault(i_req_store, i_req_funct3, i_req_addr[2:0]);

    lsu_lane u_lane (
        .i_rdata (i_mem_rdata),
        .i_wdata (r_wdata),
        .i_off   (r_addr[2:0]),
        .i_f3    (r_f3),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_f3        <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store <= i_req_store;
                        r_f3    <= i_req_funct3;
                        r_addr  <= {i_req_addr[MEM_IDX_W+2:3], w_req_off};
                        r_wdata <= i_req_wdata;
                        r_rdata <= '0;
                        r_fault <= w_req_fault;
                        if (w_req_fault) begin
                            r_state <= S_RESP;
                        end else if (i_req_store && (i_req_funct3 == F3_D)) begin
                            // Full doubleword store: nothing to merge, skip the read.
                            r_mem_wdata <= i_req_wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    // i_mem_rdata was captured by memory at this cycle's negedge.
                    if (r_store) begin
                        r_mem_wdata <= w_merge;
                        r_state     <= S_WR;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= S_RESP;
                    end
                end
                S_WR: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state so an async reset removes them at once.
    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_mem_read   = (r_state == S_RD);
    assign o_mem_write  = (r_state == S_WR);
    assign o_mem_addr   = {{(XLEN-MEM_IDX_W){1'b0}}, r_addr[MEM_IDX_W+2:3]};
    assign o_mem_wdata  = r_mem_wdata;
    assign o_resp_rdata = r_rdata;
    assign o_resp_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against a byte-level reference model.
// Latency: n/a. Build option followed: MISALIGN_TRAP_EN.
// Backpressure: randomized resp_ready, with a forced hold window.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_store = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [63:0] i_req_addr = '0;
    logic [63:0] i_req_wdata = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [63:0] o_resp_rdata;
    logic        o_resp_fault;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [63:0] i_mem_rdata = '0;

    load_store_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_store  (i_req_store),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_fault (o_resp_fault),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        bit          fault;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem [1024];
    logic [7:0]  ref_bytes [8192];
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          last_rd = 0;
    int          last_wr = 0;
    int          last_hs = 0;
    int          last_acc = 0;
    bit          busy = 0;
    bit          hold = 0;
    logic [63:0] held_rdata;
    logic        held_fault;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Byte-addressed reference: computes the response and applies stores to ref_bytes.
    task automatic model(input bit st, input bit [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output exp_t e);
        int              size;
        longint unsigned ua;
        longint unsigned base;
        bit              flt;
        logic [63:0]     v;
        size = 1 << f3[1:0];
        ua   = a;
        flt  = st ? f3[2] : (f3 == 3'd7);
`ifdef MISALIGN_TRAP_EN
        if ((ua % size) != 0) flt = 1;
`else
        ua = ua - (ua % size);
`endif
        e.fault = flt;
        e.rdata = '0;
        e.nrd = 0;
        e.nwr = 0;
        e.acc = 0;
        if (flt) begin
            e.lat = 1;
            return;
        end
        base = ((ua / 8) % 1024) * 8 + (ua % 8);
        if (!st) begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[base + i];
            if (!f3[2] && size < 8 && v[8*size-1])
                for (int b = 8*size; b < 64; b++) v[b] = 1'b1;
            e.rdata = v;
            e.lat = 2;
            e.nrd = 1;
        end else begin
            for (int i = 0; i < size; i++) ref_bytes[base + i] = wd[8*i +: 8];
            e.lat = (size == 8) ? 2 : 3;
            e.nrd = (size == 8) ? 0 : 1;
            e.nwr = 1;
        end
    endtask

    // Data memory: samples mem_read/mem_write on the negedge.
    always @(negedge clk) begin
        if (o_mem_read) begin
            i_mem_rdata = mem[o_mem_addr[9:0]];
            rd_cnt++;
            chk("mem_addr_upper_rd", {10'b0, o_mem_addr[63:10]}, 64'd0);
        end
        if (o_mem_write) begin
            mem[o_mem_addr[9:0]] = o_mem_wdata;
            wr_cnt++;
            chk("mem_addr_upper_wr", {10'b0, o_mem_addr[63:10]}, 64'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        i_resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on each new response, checks stability while held.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_resp_valid) begin
            if (!busy) begin
                if (sb.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", o_resp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", o_resp_rdata, e.rdata);
                    chk("resp_fault", {63'b0, o_resp_fault}, {63'b0, e.fault});
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("rd_cycles", 64'(rd_cnt - last_rd), 64'(e.nrd));
                    chk("wr_cycles", 64'(wr_cnt - last_wr), 64'(e.nwr));
                end
                last_rd = rd_cnt;
                last_wr = wr_cnt;
                held_rdata = o_resp_rdata;
                held_fault = o_resp_fault;
                busy = 1;
            end else begin
                chk("hold_rdata", o_resp_rdata, held_rdata);
                chk("hold_fault", {63'b0, o_resp_fault}, {63'b0, held_fault});
            end
            chk("req_ready_while_resp", {63'b0, o_req_ready}, 64'd0);
            if (i_resp_ready) begin
                busy = 0;
                last_hs = cyc;
            end
        end
    end

    task automatic issue(input bit st, input bit [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        exp_t e;
        int   n;
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_store  = st;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        n = 0;
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            ncmp++;
            nfail++;
            $display("FAIL accept_timeout: req_ready %b required 1", o_req_ready);
        end else begin
            model(st, f3, a, wd, e);
            e.acc = cyc;
            sb.push_back(e);
            last_acc = cyc;
        end
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || !o_req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            ncmp++;
            nfail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        logic [63:0] w0_before;
        for (int i = 0; i < 1024; i++) begin
            w = {$urandom, $urandom};
            if (i == 0) w = 64'h8877_6655_4433_2211;
            mem[i] = w;
            for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = w[8*b +: 8];
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {63'b0, o_req_ready},  64'd1);
        chk("rst_resp_valid", {63'b0, o_resp_valid}, 64'd0);
        chk("rst_resp_rdata", o_resp_rdata,          64'd0);
        chk("rst_resp_fault", {63'b0, o_resp_fault}, 64'd0);
        chk("rst_mem_read",   {63'b0, o_mem_read},   64'd0);
        chk("rst_mem_write",  {63'b0, o_mem_write},  64'd0);
        chk("rst_mem_addr",   o_mem_addr,            64'd0);
        chk("rst_mem_wdata",  o_mem_wdata,           64'd0);
        rst_n = 1'b1;

        // Directed scenarios
        issue(0, 3'b011, 64'd0, 64'd0);                  // LD 0
        issue(0, 3'b000, 64'd7, 64'd0);                  // LB 7
        issue(0, 3'b100, 64'd7, 64'd0);                  // LBU 7
        issue(0, 3'b001, 64'd6, 64'd0);                  // LH 6
        issue(1, 3'b000, 64'd3, 64'hAB);                 // SB 3
        issue(0, 3'b011, 64'd0, 64'd0);                  // LD 0
        issue(1, 3'b011, 64'd8, 64'h0123_4567_89AB_CDEF); // SD 8
        issue(0, 3'b011, 64'd8, 64'd0);                  // LD 8
        issue(1, 3'b010, 64'd2, 64'hDEAD_BEEF_CAFE_F00D); // SW 2
        issue(0, 3'b011, 64'd0, 64'd0);                  // LD 0
        issue(0, 3'b111, 64'd0, 64'd0);                  // illegal load
        issue(1, 3'b101, 64'd16, 64'd5);                 // illegal store
        issue(0, 3'b110, 64'h1_0000_2004, 64'd0);        // LWU, wrapping address

        // Response held off for several cycles, with the next request already waiting
        wait_idle();
        hold = 1;
        issue(0, 3'b010, 64'd4, 64'd0);
        fork
            begin
                repeat (7) @(negedge clk);
                hold = 0;
            end
            issue(0, 3'b011, 64'd0, 64'd0);
        join
        chk("accept_after_hs", 64'(last_acc), 64'(last_hs + 1));

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 8191));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
        end

        // Reset during the RD cycle of SB 0
        wait_idle();
        w0_before = {ref_bytes[7], ref_bytes[6], ref_bytes[5], ref_bytes[4],
                     ref_bytes[3], ref_bytes[2], ref_bytes[1], ref_bytes[0]};
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_store  = 1'b1;
        i_req_funct3 = 3'b000;
        i_req_addr   = 64'd0;
        i_req_wdata  = 64'h5A;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        chk("rd_before_reset", {63'b0, o_mem_read}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_read",  {63'b0, o_mem_read},  64'd0);
        chk("reset_drops_write", {63'b0, o_mem_write}, 64'd0);
        repeat (2) @(negedge clk);
        last_rd = rd_cnt;
        last_wr = wr_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready",  {63'b0, o_req_ready},  64'd1);
        chk("post_reset_resp_valid", {63'b0, o_resp_valid}, 64'd0);
        chk("word0_unchanged", mem[0], w0_before);
        issue(0, 3'b011, 64'd0, 64'd0);

        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
